// File: rtl/serial_adder_pkg.sv
// Shared constants for the serial adder: FSM state encodings.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell fed LSB-first, carry closed through a flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             s, co;

  full_adder u_fa (
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .Cin (carry),
    .Sum (s),
    .Cout(co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry   <= cin;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= {s, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= co;
          if (bit_cnt == LAST) begin
            // Counter parks at zero instead of wrapping past WIDTH-1.
            bit_cnt <= '0;
            sum     <= {s, res_sr[WIDTH-1:1]};
            cout    <= co;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
